upsample2x: RTL and testbench

Nearest-neighbour 2x upscaler for the CNN feature-map stream: accepts a W_IN x H_IN raster-order frame of signed 12-bit activations and emits a 2·W_IN x 2·H_IN raster stream in which every input pixel is replicated into a 2x2 block. It is the decoder-side counterpart of the pooling/subsampling stage and restores spatial resolution ahead of the output or overlay stage. A one-row line buffer replays each input row for the odd output row. Valid/ready handshakes on both sides throttle the 4x rate expansion.

---
 rtl/upsample2x_pkg.sv | 19 +
 rtl/upsample2x_if.sv | 27 ++
 rtl/upsample2x_line_buffer.sv | 35 +++
 rtl/upsample2x.sv | 172 +++++++++++++++++
 tb/tb_upsample2x.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/upsample2x_pkg.sv
// Shared types and constants for the 2x nearest-neighbour upscaler.
package upsample2x_pkg;

    localparam int DATA_W  = 12;  // signed activation width
    localparam int COORD_W = 10;  // output coordinate width (up to 1024 columns/rows)

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef logic        [COORD_W-1:0] coord_t;

    // ROW_EVEN: accept input and emit each pixel twice
    // PREFETCH: bubble while the first line-buffer entry is read
    // ROW_ODD:  replay the buffered row, each entry twice
    typedef enum logic [1:0] {
        ROW_EVEN = 2'd0,
        PREFETCH = 2'd1,
        ROW_ODD  = 2'd2
    } state_e;

endpackage

// File: rtl/upsample2x_if.sv
// Stream interface: input pixel handshake plus output pixel/coordinate handshake.
interface upsample2x_if;
    import upsample2x_pkg::*;

    logic   valid_in;
    pixel_t data_in;
    logic   in_ready;
    logic   valid_out;
    pixel_t data_out;
    coord_t x_out;
    coord_t y_out;
    logic   frame_end;
    logic   out_ready;

    // Upscaler side
    modport slave (
        input  valid_in, data_in, out_ready,
        output in_ready, valid_out, data_out, x_out, y_out, frame_end
    );

    // Upstream source / downstream sink side
    modport master (
        output valid_in, data_in, out_ready,
        input  in_ready, valid_out, data_out, x_out, y_out, frame_end
    );

endinterface

// File: rtl/upsample2x_line_buffer.sv
// One-row line buffer: single write port, single synchronous (1-cycle) read port.
module upsample2x_line_buffer
    import upsample2x_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  pixel_t            wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output pixel_t            rd_data
);

    pixel_t mem [DEPTH];
    pixel_t rd_data_q;

    // Storage write and registered read; read data holds until the next read.
    // NOTE: storage deliberately has no reset -- every entry is rewritten in the
    // even row before the odd row reads it, so a reset would only cost area.
    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/upsample2x.sv
// Nearest-neighbour 2x upscaler: each input pixel becomes a 2x2 output block.
// Even output rows come straight from the hold register; odd output rows are
// replayed from the line buffer.
module upsample2x
    import upsample2x_pkg::*;
#(
    parameter int W_IN = 64,
    parameter int H_IN = 64
) (
    input logic        clk,
    input logic        rst,
    upsample2x_if.slave bus
);

    localparam int ADDR_W = $clog2(W_IN);
    localparam int COL_W  = $clog2(W_IN + 1);  // column counter must reach W_IN
    localparam int ROW_W  = $clog2(H_IN + 1);

    localparam logic [COL_W-1:0] COL_END  = COL_W'(W_IN);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(W_IN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H_IN - 1);

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;     // even row: pixels accepted; odd row: entry shown
    logic [ROW_W-1:0]   row_q, row_d;
    logic               phase_q, phase_d; // 0: first copy, 1: second copy
    logic               valid_q, valid_d; // hold register occupied == valid_out
    pixel_t             data_q, data_d;
    coord_t             x_q, x_d;
    coord_t             y_q, y_d;

    logic [COL_W-1:0]   col_inc;
    logic               in_ready_c;
    logic               in_fire;
    logic               out_fire;

    logic               lb_wr_en;
    logic               lb_rd_en;
    logic [ADDR_W-1:0]  lb_rd_addr;
    pixel_t             lb_rd_data;

    assign col_inc  = col_q + COL_W'(1);
    // A new pixel may enter while the hold register is empty or is being
    // vacated by its second copy this very cycle (gap-free back-to-back).
    assign in_ready_c = !rst && (state_q == ROW_EVEN) && (col_q < COL_END)
                        && (!valid_q || (phase_q && bus.out_ready));
    assign in_fire  = bus.valid_in && in_ready_c;
    assign out_fire = valid_q && bus.out_ready;

    upsample2x_line_buffer #(
        .DEPTH  (W_IN),
        .ADDR_W (ADDR_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (col_q[ADDR_W-1:0]),
        .wr_data (bus.data_in),
        .rd_en   (lb_rd_en),
        .rd_addr (lb_rd_addr),
        .rd_data (lb_rd_data)
    );

    // Next-state, counters, hold/phase and line-buffer control.
    // NOTE: every signal is defaulted first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        phase_d    = phase_q;
        valid_d    = valid_q;
        data_d     = data_q;
        x_d        = x_q;
        y_d        = y_q;
        lb_wr_en   = 1'b0;
        lb_rd_en   = 1'b0;
        lb_rd_addr = col_q[ADDR_W-1:0];

        case (state_q)
            ROW_EVEN: begin
                if (in_fire) begin
                    lb_wr_en = 1'b1;
                    data_d   = bus.data_in;
                    valid_d  = 1'b1;
                    phase_d  = 1'b0;
                    x_d      = coord_t'(col_q) << 1;
                    y_d      = coord_t'(row_q) << 1;
                    col_d    = col_inc;
                end else if (out_fire) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        x_d     = x_q + coord_t'(1);
                    end else begin
                        valid_d = 1'b0;
                        phase_d = 1'b0;
                        if (col_q == COL_END) begin
                            state_d = PREFETCH;
                            col_d   = '0;
                        end
                    end
                end
            end

            PREFETCH: begin
                lb_rd_en = 1'b1;  // address 0, data ready next cycle
                state_d  = ROW_ODD;
                valid_d  = 1'b1;
                phase_d  = 1'b0;
                x_d      = '0;
                y_d      = (coord_t'(row_q) << 1) | coord_t'(1);
            end

            ROW_ODD: begin
                if (out_fire) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        x_d     = x_q + coord_t'(1);
                    end else if (col_q == COL_LAST) begin
                        valid_d = 1'b0;
                        phase_d = 1'b0;
                        state_d = ROW_EVEN;
                        col_d   = '0;
                        row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        lb_rd_en   = 1'b1;
                        lb_rd_addr = col_inc[ADDR_W-1:0];
                        col_d      = col_inc;
                        phase_d    = 1'b0;
                        x_d        = x_q + coord_t'(1);
                    end
                end
            end

            default: begin
                state_d = ROW_EVEN;
            end
        endcase
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ROW_EVEN;
            col_q   <= '0;
            row_q   <= '0;
            phase_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Odd rows show the line-buffer read register directly; it only changes on
    // a second-copy transfer, so it stays stable while stalled.
    assign bus.in_ready  = in_ready_c;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = (state_q == ROW_ODD) ? lb_rd_data : data_q;
    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;
    assign bus.frame_end = valid_q && (state_q == ROW_ODD) && phase_q
                           && (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: tb/tb_upsample2x.sv
// Scoreboard bench for upsample2x: expected 2x2-replicated frames are queued
// when a frame is offered and popped as output transfers occur.
module tb_upsample2x;
    import upsample2x_pkg::*;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PERIOD = 4 * W + 2;  // cycles per input row under no stall

    typedef struct packed {
        pixel_t data;
        coord_t x;
        coord_t y;
        logic   fe;
    } out_t;

    logic clk = 1'b0;
    logic rst;

    upsample2x_if bus ();

    upsample2x #(.W_IN(W), .H_IN(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    int     stall_pct = 0;
    pixel_t in_q[$];
    out_t   exp_q[$];
    pixel_t frame [W*H];

    out_t   prev_out;
    logic   prev_stall = 1'b0;
    logic   s_in_ready;
    logic   s_valid;
    coord_t s_y;
    int     first_in_cyc, first_out_cyc, fe_cyc, next_out_cyc, fe_count;

    function automatic out_t cur_out();
        out_t o;
        o.data = bus.data_out;
        o.x    = bus.x_out;
        o.y    = bus.y_out;
        o.fe   = bus.frame_end;
        return o;
    endfunction

    // Queue the current frame[] as input and its 2x2-replicated expectation.
    task automatic push_frame();
        out_t e;
        for (int i = 0; i < W * H; i++) in_q.push_back(frame[i]);
        for (int oy = 0; oy < 2 * H; oy++) begin
            for (int ox = 0; ox < 2 * W; ox++) begin
                e.data = frame[(oy / 2) * W + (ox / 2)];
                e.x    = coord_t'(ox);
                e.y    = coord_t'(oy);
                e.fe   = (ox == 2 * W - 1) && (oy == 2 * H - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < W * H; i++) frame[i] = pixel_t'($urandom_range(0, 4095));
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // then let the rising edge perform the transfers.
    task automatic step();
        out_t o;
        @(negedge clk);
        bus.out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
        bus.valid_in  = (in_q.size() != 0);
        bus.data_in   = (in_q.size() != 0) ? in_q[0] : pixel_t'(0);
        #1;
        o = cur_out();
        if (prev_stall) begin
            total++;
            if (!bus.valid_out || o !== prev_out) begin
                bad++;
                $display("FAIL stall_hold: got valid=%0b data=%0d x=%0d y=%0d, held data=%0d x=%0d y=%0d",
                         bus.valid_out, o.data, o.x, o.y, prev_out.data, prev_out.x, prev_out.y);
            end
        end
        if (bus.valid_out) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_output: got data=%0d x=%0d y=%0d, expected no output",
                         o.data, o.x, o.y);
            end else begin
                if (o !== exp_q[0]) begin
                    bad++;
                    $display("FAIL out_pixel: got data=%0d x=%0d y=%0d fe=%0b, expected data=%0d x=%0d y=%0d fe=%0b",
                             o.data, o.x, o.y, o.fe,
                             exp_q[0].data, exp_q[0].x, exp_q[0].y, exp_q[0].fe);
                end
                if (bus.out_ready) void'(exp_q.pop_front());
            end
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (fe_cyc >= 0 && next_out_cyc < 0 && cyc > fe_cyc) next_out_cyc = cyc;
            if (bus.out_ready && bus.frame_end) begin
                fe_count++;
                if (fe_cyc < 0) fe_cyc = cyc;
            end
        end
        prev_stall = bus.valid_out && !bus.out_ready;
        prev_out   = o;
        s_in_ready = bus.in_ready;
        s_valid    = bus.valid_out;
        s_y        = bus.y_out;
        if (bus.valid_in && bus.in_ready) begin
            void'(in_q.pop_front());
            if (first_in_cyc < 0) first_in_cyc = cyc;
        end
        cyc++;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        total++;
        if (in_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d inputs and %0d outputs pending, expected 0",
                     name, in_q.size(), exp_q.size());
            in_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic clear_marks();
        first_in_cyc = -1; first_out_cyc = -1;
        fe_cyc = -1; next_out_cyc = -1; fe_count = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== '0 || bus.x_out !== '0 ||
            bus.y_out !== '0 || bus.frame_end !== 1'b0) begin
            bad++;
            $display("FAIL %s_outputs: got valid=%0b data=%0d x=%0d y=%0d fe=%0b, expected all 0",
                     name, bus.valid_out, bus.data_out, bus.x_out, bus.y_out, bus.frame_end);
        end
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_in_ready: got %0b, expected 0", name, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_in  = 1'b1;
        bus.data_in   = pixel_t'(5);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_in_ready: got %0b, expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        stall_pct = 0;
        clear_marks();
        for (int i = 0; i < W * H; i++) frame[i] = pixel_t'(i + 1);
        push_frame();
        drain(400, "basic");
        total++;
        if (first_out_cyc != first_in_cyc + 1) begin
            bad++;
            $display("FAIL latency: got first output %0d cycles after first input, expected 1",
                     first_out_cyc - first_in_cyc);
        end
        total++;
        if (fe_count != 1) begin
            bad++;
            $display("FAIL frame_end_count: got %0d, expected 1", fe_count);
        end
    endtask

    task automatic test_extremes();
        pixel_t ext [4];
        ext[0] = -12'sd2048; ext[1] = 12'sd2047; ext[2] = -12'sd1; ext[3] = 12'sd0;
        stall_pct = 0;
        clear_marks();
        for (int i = 0; i < W * H; i++) frame[i] = ext[i % 4];
        push_frame();
        drain(400, "extremes");
    endtask

    task automatic test_stall();
        stall_pct = 50;
        clear_marks();
        random_frame();
        push_frame();
        drain(3000, "stall");
        stall_pct = 0;
    endtask

    task automatic test_in_ready_pattern();
        logic want;
        stall_pct = 0;
        clear_marks();
        random_frame();
        push_frame();
        for (int c = 0; c < PERIOD * H; c++) begin
            step();
            want = ((c % PERIOD) < 2 * W) && ((c % PERIOD) % 2 == 0);
            total++;
            if (s_in_ready !== want) begin
                bad++;
                $display("FAIL in_ready_pattern: cycle %0d got %0b, expected %0b", c, s_in_ready, want);
            end
        end
        drain(50, "in_ready");
    endtask

    task automatic test_back_to_back();
        stall_pct = 0;
        clear_marks();
        random_frame();
        push_frame();
        random_frame();
        push_frame();
        drain(800, "back_to_back");
        total++;
        if (fe_count != 2) begin
            bad++;
            $display("FAIL b2b_frame_end_count: got %0d, expected 2", fe_count);
        end
        total++;
        if (fe_cyc < 0 || next_out_cyc < 0 || next_out_cyc - fe_cyc > 2) begin
            bad++;
            $display("FAIL b2b_gap: got next output %0d cycles after frame_end, expected <= 2",
                     next_out_cyc - fe_cyc);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        stall_pct = 0;
        clear_marks();
        random_frame();
        push_frame();
        s_valid = 1'b0;
        s_y     = '0;
        while (!(s_valid && s_y == coord_t'(3)) && n < 300) begin
            step();
            n++;
        end
        total++;
        if (!(s_valid && s_y == coord_t'(3))) begin
            bad++;
            $display("FAIL mid_reset_reach_row3: got y=%0d valid=%0b, expected y=3 valid=1", s_y, s_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        in_q.delete();
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.valid_in = 1'b0;
        for (int i = 0; i < W * H; i++) frame[i] = pixel_t'(100 - 7 * i);
        push_frame();
        drain(400, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_stall();
        test_in_ready_pattern();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
